exec_control: RTL and testbench

//  Decode/execute stage directly downstream of the instruction ROM + PC block.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/exec_control_if.sv | 28 ++
 rtl/regfile6.sv | 44 ++++
 rtl/exec_control.sv | 160 ++++++++++++++++
 tb/tb_exec_control.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field widths, opcodes, register specifiers
// and the execute-stage FSM states. Imported by the ROM/PC block and exec_control.
package cpu_pkg;
  localparam int OP_SIZE  = 4;
  localparam int ARG_SIZE = 3;
  localparam int ARG_NUM  = 2;
  localparam int DATA_W   = 8;
  localparam int PC_W     = 4;
  localparam int INSTR_W  = OP_SIZE + ARG_NUM * ARG_SIZE;

  localparam logic [OP_SIZE-1:0] OP_LOAD = 4'b0000;
  localparam logic [OP_SIZE-1:0] OP_MOVE = 4'b0001;
  localparam logic [OP_SIZE-1:0] OP_ADD  = 4'b0010;
  localparam logic [OP_SIZE-1:0] OP_XOR  = 4'b0011;
  localparam logic [OP_SIZE-1:0] OP_BR   = 4'b1000;
  localparam logic [OP_SIZE-1:0] OP_HALT = 4'b1111;

  localparam logic [ARG_SIZE-1:0] SPEC_NA = 3'd0;
  localparam logic [ARG_SIZE-1:0] SPEC_R1 = 3'd1;
  localparam logic [ARG_SIZE-1:0] SPEC_R2 = 3'd2;
  localparam logic [ARG_SIZE-1:0] SPEC_R3 = 3'd3;
  localparam logic [ARG_SIZE-1:0] SPEC_R4 = 3'd4;
  localparam logic [ARG_SIZE-1:0] SPEC_R5 = 3'd5;
  localparam logic [ARG_SIZE-1:0] SPEC_R6 = 3'd6;
  localparam logic [ARG_SIZE-1:0] SPEC_PC = 3'd7;

  typedef enum logic [1:0] {
    ST_EXEC      = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_HALT      = 2'd2
  } state_t;

  function automatic logic [INSTR_W-1:0] mk_instr(input logic [OP_SIZE-1:0] op,
                                                  input logic [ARG_SIZE-1:0] a1,
                                                  input logic [ARG_SIZE-1:0] a2);
    return {op, a1, a2};
  endfunction
endpackage

// File: rtl/exec_control_if.sv
// Execute-stage bus: ROM word in, LOAD data handshake, PC branch feedback,
// status flags and the register-file debug port.
interface exec_control_if;
  import cpu_pkg::*;

  logic [INSTR_W-1:0]  instruction;
  logic [DATA_W-1:0]   din;
  logic                din_valid;
  logic                din_ready;
  logic                branch;
  logic [PC_W-1:0]     branchaddress;
  logic                zero;
  logic                carry;
  logic                halted;
  logic                illegal;
  logic [ARG_SIZE-1:0] dbg_sel;
  logic [DATA_W-1:0]   dbg_data;

  modport master (
    output instruction, din, din_valid, dbg_sel,
    input  din_ready, branch, branchaddress, zero, carry, halted, illegal, dbg_data
  );

  modport slave (
    input  instruction, din, din_valid, dbg_sel,
    output din_ready, branch, branchaddress, zero, carry, halted, illegal, dbg_data
  );
endinterface

// File: rtl/regfile6.sv
// Six-entry register file, two read ports plus debug read, one write port.
// Specifier 0 reads zero, specifier 7 reads the PC mirror; writes to either are dropped.
module regfile6
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_W-1:0]     pc,
  input  logic [ARG_SIZE-1:0] ra1,
  input  logic [ARG_SIZE-1:0] ra2,
  input  logic [ARG_SIZE-1:0] dbg_sel,
  output logic [DATA_W-1:0]   rd1,
  output logic [DATA_W-1:0]   rd2,
  output logic [DATA_W-1:0]   dbg_data,
  input  logic                we,
  input  logic [ARG_SIZE-1:0] wa,
  input  logic [DATA_W-1:0]   wd
);
  logic [5:0][DATA_W-1:0] r;

  function automatic logic [DATA_W-1:0] rd_spec(input logic [ARG_SIZE-1:0] s,
                                                input logic [5:0][DATA_W-1:0] rf,
                                                input logic [PC_W-1:0] p);
    logic [DATA_W-1:0] v;
    v = '0;
    case (s)
      SPEC_NA: v = '0;
      SPEC_PC: v = {{(DATA_W-PC_W){1'b0}}, p};
      default: v = rf[s - 3'd1];
    endcase
    return v;
  endfunction

  assign rd1      = rd_spec(ra1, r, pc);
  assign rd2      = rd_spec(ra2, r, pc);
  assign dbg_data = rd_spec(dbg_sel, r, pc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r <= '0;
    else if (we && wa != SPEC_NA && wa != SPEC_PC)
      r[wa - 3'd1] <= wd;
  end
endmodule

// File: rtl/exec_control.sv
// Decode/execute stage: runs one instruction per cycle against regfile6 and
// feeds branch/branchaddress to the PC; stalls are branch-to-self.
module exec_control
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  exec_control_if.slave bus
);
  logic [OP_SIZE-1:0]  op;
  logic [ARG_SIZE-1:0] a1, a2;
  assign op = bus.instruction[INSTR_W-1 -: OP_SIZE];
  assign a1 = bus.instruction[2*ARG_SIZE-1 -: ARG_SIZE];
  assign a2 = bus.instruction[ARG_SIZE-1:0];

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic            zero_q, carry_q, illegal_q;

  logic [DATA_W-1:0]   rd1, rd2, wd, result, xor_res;
  logic [DATA_W:0]     sum;
  logic [ARG_SIZE-1:0] wa, dst;
  logic                we, has_res, flag_we, zero_n, carry_n, set_illegal;
  logic                branch_c;
  logic [PC_W-1:0]     ba_c;

  regfile6 u_rf (
    .clk      (clk),
    .rst      (rst),
    .pc       (pc_q),
    .ra1      (a1),
    .ra2      (a2),
    .dbg_sel  (bus.dbg_sel),
    .rd1      (rd1),
    .rd2      (rd2),
    .dbg_data (bus.dbg_data),
    .we       (we),
    .wa       (wa),
    .wd       (wd)
  );

  assign sum     = {1'b0, rd1} + {1'b0, rd2};
  assign xor_res = rd1 ^ rd2;

  always_comb begin
    state_d     = state_q;
    has_res     = 1'b0;
    result      = '0;
    dst         = a1;
    flag_we     = 1'b0;
    zero_n      = zero_q;
    carry_n     = carry_q;
    set_illegal = 1'b0;
    branch_c    = 1'b0;
    ba_c        = '0;
    we          = 1'b0;
    wa          = a1;
    wd          = '0;
    case (state_q)
      ST_EXEC: begin
        case (op)
          OP_LOAD: begin
            if (bus.din_valid) begin
              has_res = 1'b1;
              result  = bus.din;
            end else begin
              state_d  = ST_LOAD_WAIT;
              branch_c = 1'b1;
              ba_c     = pc_q;
            end
          end
          OP_MOVE: begin
            has_res = 1'b1;
            dst     = a2;
            result  = rd1;
          end
          OP_ADD: begin
            has_res = 1'b1;
            result  = sum[DATA_W-1:0];
            flag_we = 1'b1;
            zero_n  = (sum[DATA_W-1:0] == '0);
            carry_n = sum[DATA_W];
          end
          OP_XOR: begin
            has_res = 1'b1;
            result  = xor_res;
            flag_we = 1'b1;
            zero_n  = (xor_res == '0);
            carry_n = 1'b0;
          end
          OP_BR: begin
            branch_c = 1'b1;
            ba_c     = bus.instruction[PC_W-1:0];
          end
          OP_HALT: begin
            // Park the PC on the HALT word itself
            state_d  = ST_HALT;
            branch_c = 1'b1;
            ba_c     = pc_q;
          end
          default: set_illegal = 1'b1;
        endcase
      end
      ST_LOAD_WAIT: begin
        if (bus.din_valid) begin
          has_res = 1'b1;
          result  = bus.din;
          state_d = ST_EXEC;
        end else begin
          branch_c = 1'b1;
          ba_c     = pc_q;
        end
      end
      ST_HALT: begin
        branch_c = 1'b1;
        ba_c     = pc_q;
      end
      default: state_d = ST_EXEC;
    endcase

    // Writing the PC specifier turns the result into a jump instead of a write
    if (has_res) begin
      if (dst == SPEC_PC) begin
        branch_c = 1'b1;
        ba_c     = result[PC_W-1:0];
      end else begin
        we = 1'b1;
        wa = dst;
        wd = result;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_EXEC;
      pc_q      <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= branch_c ? ba_c : pc_q + 1'b1;
      if (flag_we) begin
        zero_q  <= zero_n;
        carry_q <= carry_n;
      end
      if (set_illegal)
        illegal_q <= 1'b1;
    end
  end

  assign bus.branch        = branch_c & ~rst;
  assign bus.branchaddress = rst ? '0 : ba_c;
  assign bus.din_ready     = (op == OP_LOAD) && (state_q != ST_HALT);
  assign bus.zero          = zero_q;
  assign bus.carry         = carry_q;
  assign bus.halted        = (state_q == ST_HALT);
  assign bus.illegal       = illegal_q;
endmodule

// File: tb/tb_exec_control.sv
// Scoreboard bench for exec_control: each step queues its post-edge expectation,
// combinational outputs are checked before the edge, register/flag state after it.
module tb_exec_control;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exec_control_if bus();
  exec_control dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    string          tag;
    logic [2:0]     sel;
    logic [7:0]     val;
    logic           z;
    logic           c;
    logic           ill;
    logic           hlt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [9:0] ins, input logic [7:0] d,
                      input logic dv, input logic ebr, input logic [3:0] eba,
                      input logic erdy, input logic [2:0] sel, input logic [7:0] val,
                      input logic z, input logic c, input logic ill, input logic hlt);
    exp_t e;
    @(negedge clk);
    bus.instruction = ins;
    bus.din         = d;
    bus.din_valid   = dv;
    e = '{tag: tag, sel: sel, val: val, z: z, c: c, ill: ill, hlt: hlt};
    sb.push_back(e);
    #1;
    chk({tag, ".br"}, 32'(bus.branch), 32'(ebr));
    if (ebr) chk({tag, ".ba"}, 32'(bus.branchaddress), 32'(eba));
    chk({tag, ".rdy"}, 32'(bus.din_ready), 32'(erdy));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    bus.dbg_sel = e.sel;
    #1;
    chk({e.tag, ".reg"}, 32'(bus.dbg_data), 32'(e.val));
    chk({e.tag, ".z"},   32'(bus.zero),     32'(e.z));
    chk({e.tag, ".c"},   32'(bus.carry),    32'(e.c));
    chk({e.tag, ".ill"}, 32'(bus.illegal),  32'(e.ill));
    chk({e.tag, ".hlt"}, 32'(bus.halted),   32'(e.hlt));
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] sel, input logic [7:0] val);
    bus.dbg_sel = sel;
    #1;
    chk(tag, 32'(bus.dbg_data), 32'(val));
  endtask

  initial begin
    logic [9:0] ld_r1, ld_r2, ld_r3, ld_r4, ld_r5, ld_na;
    ld_r1 = mk_instr(OP_LOAD, SPEC_R1, SPEC_NA);
    ld_r2 = mk_instr(OP_LOAD, SPEC_R2, SPEC_NA);
    ld_r3 = mk_instr(OP_LOAD, SPEC_R3, SPEC_NA);
    ld_r4 = mk_instr(OP_LOAD, SPEC_R4, SPEC_NA);
    ld_r5 = mk_instr(OP_LOAD, SPEC_R5, SPEC_NA);
    ld_na = mk_instr(OP_LOAD, SPEC_NA, SPEC_NA);

    bus.instruction = ld_r1;
    bus.din         = 8'h00;
    bus.din_valid   = 1'b0;
    bus.dbg_sel     = SPEC_R1;
    #2;
    chk("rst.br",  32'(bus.branch),    32'd0);
    chk("rst.rdy", 32'(bus.din_ready), 32'd1);
    chk("rst.z",   32'(bus.zero),      32'd0);
    chk("rst.c",   32'(bus.carry),     32'd0);
    chk("rst.ill", 32'(bus.illegal),   32'd0);
    chk("rst.hlt", 32'(bus.halted),    32'd0);
    chk_reg("rst.r1", SPEC_R1, 8'h00);
    chk_reg("rst.r6", SPEC_R6, 8'h00);
    chk_reg("rst.na", SPEC_NA, 8'h00);
    chk_reg("rst.pc", SPEC_PC, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // LOAD with data ready, then a stalled LOAD
    step("ld_r1",   ld_r1, 8'h5A, 1, 0, 4'h0, 1, SPEC_R1, 8'h5A, 0, 0, 0, 0);
    step("ldw0",    ld_r2, 8'h00, 0, 1, 4'h1, 1, SPEC_R2, 8'h00, 0, 0, 0, 0);
    step("ldw1",    ld_r2, 8'h00, 0, 1, 4'h1, 1, SPEC_R2, 8'h00, 0, 0, 0, 0);
    step("ldw2",    ld_r2, 8'h00, 0, 1, 4'h1, 1, SPEC_R2, 8'h00, 0, 0, 0, 0);
    step("ldw_go",  ld_r2, 8'h33, 1, 0, 4'h0, 1, SPEC_R2, 8'h33, 0, 0, 0, 0);
    step("pc_inc",  ld_r1, 8'h00, 0, 1, 4'h2, 1, SPEC_R1, 8'h5A, 0, 0, 0, 0);
    step("ld_ff",   ld_r1, 8'hFF, 1, 0, 4'h0, 1, SPEC_R1, 8'hFF, 0, 0, 0, 0);
    step("ld_01",   ld_r2, 8'h01, 1, 0, 4'h0, 1, SPEC_R2, 8'h01, 0, 0, 0, 0);

    // ALU and flags
    step("add_ovf", mk_instr(OP_ADD, SPEC_R1, SPEC_R2), 8'h00, 0, 0, 4'h0, 0, SPEC_R1, 8'h00, 1, 1, 0, 0);
    step("xor_self", mk_instr(OP_XOR, SPEC_R1, SPEC_R1), 8'h00, 0, 0, 4'h0, 0, SPEC_R1, 8'h00, 1, 0, 0, 0);

    // MOVE to register and to PC
    step("ld_07",   ld_r1, 8'h07, 1, 0, 4'h0, 1, SPEC_R1, 8'h07, 1, 0, 0, 0);
    step("mov_r2",  mk_instr(OP_MOVE, SPEC_R1, SPEC_R2), 8'h00, 0, 0, 4'h0, 0, SPEC_R2, 8'h07, 1, 0, 0, 0);
    step("ld_0c",   ld_r1, 8'h0C, 1, 0, 4'h0, 1, SPEC_R1, 8'h0C, 1, 0, 0, 0);
    step("mov_pc",  mk_instr(OP_MOVE, SPEC_R1, SPEC_PC), 8'h00, 0, 1, 4'hC, 0, SPEC_R2, 8'h07, 1, 0, 0, 0);
    step("fill_d",  ld_na, 8'h99, 1, 0, 4'h0, 1, SPEC_R1, 8'h0C, 1, 0, 0, 0);
    step("fill_e",  ld_na, 8'h99, 1, 0, 4'h0, 1, SPEC_R2, 8'h07, 1, 0, 0, 0);
    step("fill_f",  ld_na, 8'h99, 1, 0, 4'h0, 1, SPEC_PC, 8'h0F, 1, 0, 0, 0);

    // BR from F, ADD without carry, NOP wrap
    step("br_2",    mk_instr(OP_BR, SPEC_NA, SPEC_R2), 8'h00, 0, 1, 4'h2, 0, SPEC_PC, 8'h02, 1, 0, 0, 0);
    step("pc_is2",  ld_r3, 8'h00, 0, 1, 4'h2, 1, SPEC_R3, 8'h00, 1, 0, 0, 0);
    step("ld_9c",   ld_r3, 8'h9C, 1, 0, 4'h0, 1, SPEC_R3, 8'h9C, 1, 0, 0, 0);
    step("add_nc",  mk_instr(OP_ADD, SPEC_R3, SPEC_R1), 8'h00, 0, 0, 4'h0, 0, SPEC_R3, 8'hA8, 0, 0, 0, 0);
    step("br_f",    mk_instr(OP_BR, SPEC_R1, SPEC_PC), 8'h00, 0, 1, 4'hF, 0, SPEC_R3, 8'hA8, 0, 0, 0, 0);
    step("illegal", mk_instr(4'b0101, SPEC_R1, SPEC_R2), 8'h00, 0, 0, 4'h0, 0, SPEC_R1, 8'h0C, 0, 0, 1, 0);
    step("wrap0",   ld_r4, 8'h00, 0, 1, 4'h0, 1, SPEC_R4, 8'h00, 0, 0, 1, 0);
    step("ill_stk", ld_r4, 8'h00, 0, 1, 4'h0, 1, SPEC_R2, 8'h07, 0, 0, 1, 0);

    // Async reset while stalled in LOAD_WAIT
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rstw.br",  32'(bus.branch),  32'd0);
    chk("rstw.ill", 32'(bus.illegal), 32'd0);
    chk("rstw.z",   32'(bus.zero),    32'd0);
    chk_reg("rstw.r1", SPEC_R1, 8'h00);
    chk_reg("rstw.r3", SPEC_R3, 8'h00);
    chk_reg("rstw.pc", SPEC_PC, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // HALT freezes the PC and blocks writes
    step("ld_aa",   ld_r5, 8'hAA, 1, 0, 4'h0, 1, SPEC_R5, 8'hAA, 0, 0, 0, 0);
    step("halt",    mk_instr(OP_HALT, SPEC_NA, SPEC_NA), 8'h00, 0, 1, 4'h1, 0, SPEC_R5, 8'hAA, 0, 0, 0, 1);
    step("hlt_ld0", ld_r5, 8'h11, 1, 1, 4'h1, 0, SPEC_R5, 8'hAA, 0, 0, 0, 1);
    step("hlt_ld1", ld_r5, 8'h11, 1, 1, 4'h1, 0, SPEC_PC, 8'h01, 0, 0, 0, 1);

    // Async reset out of HALT
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rsth.hlt", 32'(bus.halted), 32'd0);
    chk("rsth.br",  32'(bus.branch), 32'd0);
    chk("rsth.rdy", 32'(bus.din_ready), 32'd1);
    chk_reg("rsth.r5", SPEC_R5, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
